axi_stream_width_conv: RTL and testbench

- Parametrised AXI-Stream byte-width converter. Accepts IN_BYTES-wide beats and emits OUT_BYTES-wide beats through an internal byte buffer, for any IN/OUT ratio.
- Successor to the fixed-width n-byte stream stage. Adds arbitrary width conversion, tlast-driven partial flush with tkeep, and a level output.
- Sits between stream producers and consumers of different widths in the datapath.

---
 rtl/axi_stream_width_conv.sv | 94 +++++++++
 tb/tb_axi_stream_width_conv.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_width_conv.sv
// AXI-Stream byte-width converter: IN_BYTES beats in, OUT_BYTES beats out through a
// shifting byte buffer; an accepted tlast drains the buffer, ending with a tkeep-masked beat.
module axi_stream_width_conv #(
    parameter int IN_BYTES    = 5,
    parameter int OUT_BYTES   = 4,
    parameter int DEPTH_BYTES = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [8*IN_BYTES-1:0]            in_tdata,
    input  logic                             in_tvalid,
    input  logic                             in_tlast,
    output logic                             in_tready,
    output logic [8*OUT_BYTES-1:0]           out_tdata,
    output logic [OUT_BYTES-1:0]             out_tkeep,
    output logic                             out_tlast,
    output logic                             out_tvalid,
    input  logic                             out_tready,
    output logic [$clog2(DEPTH_BYTES+1)-1:0] level
);
    localparam int CW = $clog2(DEPTH_BYTES+1);
    localparam int DW = 8*DEPTH_BYTES;
    localparam logic [CW-1:0] IN_N     = CW'(IN_BYTES);
    localparam logic [CW-1:0] OUT_N    = CW'(OUT_BYTES);
    localparam logic [CW-1:0] IN_LIMIT = CW'(DEPTH_BYTES - IN_BYTES);

    if (IN_BYTES < 1 || OUT_BYTES < 1) begin : g_bad_width
        $error("axi_stream_width_conv: IN_BYTES and OUT_BYTES must be >= 1");
    end
    if (DEPTH_BYTES < IN_BYTES + OUT_BYTES) begin : g_bad_depth
        $error("axi_stream_width_conv: DEPTH_BYTES must be >= IN_BYTES + OUT_BYTES");
    end

    typedef enum logic {FILL, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] mem_q, mem_d, kept, in_ext, in_mask;
    logic [CW-1:0] count_q, count_d, take, rm, base;
    logic          flush, in_fire, out_fire;

    assign flush      = (state_q == DRAIN);
    assign take       = (count_q >= OUT_N) ? OUT_N : count_q;
    // Ready looks only at registered state, so there is no path from out_tready.
    assign in_tready  = !reset && !flush && (count_q <= IN_LIMIT);
    assign out_tvalid = (count_q >= OUT_N) || (flush && count_q != '0);
    assign out_tlast  = flush && (count_q <= OUT_N);
    assign in_fire    = in_tvalid && in_tready;
    assign out_fire   = out_tvalid && out_tready;
    assign level      = count_q;

    assign in_ext  = DW'(in_tdata);
    assign in_mask = DW'({(8*IN_BYTES){1'b1}});

    for (genvar i = 0; i < OUT_BYTES; i++) begin : g_lane
        localparam logic [CW-1:0] IDX = CW'(i);
        assign out_tkeep[i]        = IDX < take;
        assign out_tdata[8*i +: 8] = out_tkeep[i] ? mem_q[8*i +: 8] : 8'h00;
    end

    // Head sits at byte 0: pop by shifting down, then append the new beat right after
    // the survivors, so a same-cycle pop and push keep byte order.
    always_comb begin
        rm      = out_fire ? take : '0;
        base    = count_q - rm;
        kept    = mem_q >> {rm, 3'b000};
        mem_d   = kept;
        count_d = base;
        if (in_fire) begin
            mem_d   = (kept & ~(in_mask << {base, 3'b000})) | (in_ext << {base, 3'b000});
            count_d = base + IN_N;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (in_fire && in_tlast)   state_d = DRAIN;
            DRAIN:   if (out_fire && out_tlast) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            mem_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_axi_stream_width_conv.sv
// Directed checks on the default 5->4 converter, then a randomized scoreboard run
// over four width ratios.
module tb_axi_stream_width_conv;
    localparam int NBEATS = 120;
    localparam logic [31:0] CFG_IN  = 32'h08_02_04_05;
    localparam logic [31:0] CFG_OUT = 32'h02_08_05_04;

    logic        clk, reset, rrst, rstart;
    logic [39:0] in_tdata;
    logic        in_tvalid, in_tlast, in_tready;
    logic [31:0] out_tdata;
    logic [3:0]  out_tkeep;
    logic        out_tlast, out_tvalid, out_tready;
    logic [4:0]  level;
    int          checks, errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    axi_stream_width_conv #(.IN_BYTES(5), .OUT_BYTES(4), .DEPTH_BYTES(16)) u_dut (
        .clk(clk), .reset(reset),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .level(level)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the beat is accepted.
    task automatic send(input logic [39:0] d, input logic l);
        int n = 0;
        in_tdata = d; in_tlast = l; in_tvalid = 1'b1;
        while (!in_tready && n < 50) begin @(negedge clk); n++; end
        chk("send_stall", n < 50, 1);
        @(negedge clk);
        in_tvalid = 1'b0; in_tlast = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                               input logic l);
        int n = 0;
        while (!(out_tvalid && out_tready) && n < 40) begin @(negedge clk); n++; end
        chk({tag, "_wait"}, n < 40, 1);
        chk({tag, "_data"}, out_tdata, d);
        chk({tag, "_keep"}, out_tkeep, k);
        chk({tag, "_last"}, out_tlast, l);
        @(negedge clk);
    endtask

    task automatic out_pulse();
        out_tready = 1'b1;
        @(negedge clk);
        out_tready = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; rrst = 1'b1; rstart = 1'b0;
        in_tdata = '0; in_tvalid = 1'b0; in_tlast = 1'b0; out_tready = 1'b0;

        // reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_in_tready", in_tready, 0);
            chk("rst_out_tvalid", out_tvalid, 0);
            chk("rst_level", level, 0);
        end
        chk("rst_tdata", out_tdata, 0);
        chk("rst_tkeep", out_tkeep, 0);
        chk("rst_tlast", out_tlast, 0);
        reset = 1'b0;
        #1 chk("rel_in_tready", in_tready, 1);
        @(negedge clk);

        // streaming 5->4
        out_tready = 1'b1;
        fork
            begin
                send(40'h0403020100, 1'b0);
                send(40'h0908070605, 1'b0);
                send(40'h0E0D0C0B0A, 1'b0);
                send(40'h131211100F, 1'b1);
            end
            begin
                expect_beat("st0", 32'h03020100, 4'hF, 1'b0);
                expect_beat("st1", 32'h07060504, 4'hF, 1'b0);
                expect_beat("st2", 32'h0B0A0908, 4'hF, 1'b0);
                expect_beat("st3", 32'h0F0E0D0C, 4'hF, 1'b0);
                expect_beat("st4", 32'h13121110, 4'hF, 1'b1);
            end
        join
        chk("st_level", level, 0);
        chk("st_in_tready", in_tready, 1);

        // partial flush
        send(40'h4443424140, 1'b1);
        chk("pf0_level", level, 5);
        chk("pf0_in_tready", in_tready, 0);
        chk("pf0_valid", out_tvalid, 1);
        chk("pf0_data", out_tdata, 32'h43424140);
        chk("pf0_keep", out_tkeep, 4'hF);
        chk("pf0_last", out_tlast, 0);
        @(negedge clk);
        chk("pf1_level", level, 1);
        chk("pf1_in_tready", in_tready, 0);
        chk("pf1_data", out_tdata, 32'h00000044);
        chk("pf1_keep", out_tkeep, 4'h1);
        chk("pf1_last", out_tlast, 1);
        @(negedge clk);
        chk("pf2_in_tready", in_tready, 1);
        chk("pf2_valid", out_tvalid, 0);
        chk("pf2_level", level, 0);

        // backpressure
        out_tready = 1'b0;
        send(40'h5453525150, 1'b0);
        chk("bp_level5", level, 5);
        send(40'h5958575655, 1'b0);
        chk("bp_level10", level, 10);
        send(40'h5E5D5C5B5A, 1'b0);
        chk("bp_level15", level, 15);
        chk("bp_full_ready", in_tready, 0);
        chk("bp_head", out_tdata, 32'h53525150);
        out_tready = 1'b1;
        in_tdata = 40'h636261605F; in_tlast = 1'b1; in_tvalid = 1'b1;
        @(negedge clk);
        chk("bp_level11", level, 11);
        chk("bp_ready11", in_tready, 1);
        chk("bp_beat1", out_tdata, 32'h57565554);
        @(negedge clk);
        in_tvalid = 1'b0; in_tlast = 1'b0;
        chk("bp_level12", level, 12);
        expect_beat("bp2", 32'h5B5A5958, 4'hF, 1'b0);
        expect_beat("bp3", 32'h5F5E5D5C, 4'hF, 1'b0);
        expect_beat("bp4", 32'h63626160, 4'hF, 1'b1);
        chk("bp_empty", level, 0);

        // simultaneous in/out at level 4
        out_tready = 1'b0;
        send(40'h7473727170, 1'b0);
        out_pulse();
        chk("sim_level1", level, 1);
        send(40'h7978777675, 1'b0);
        out_pulse();
        send(40'h7E7D7C7B7A, 1'b0);
        out_pulse();
        send(40'h838281807F, 1'b0);
        out_pulse();
        chk("sim_level4", level, 4);
        chk("sim_head4", out_tdata, 32'h83828180);
        out_tready = 1'b1;
        send(40'h8887868584, 1'b1);
        chk("sim_level5", level, 5);
        chk("sim_head_byte", out_tdata[7:0], 8'h84);
        chk("sim_head5", out_tdata, 32'h87868584);
        @(negedge clk);
        chk("sim_tail", out_tdata, 32'h00000088);
        chk("sim_tail_keep", out_tkeep, 4'h1);
        chk("sim_tail_last", out_tlast, 1);
        @(negedge clk);
        chk("sim_empty", level, 0);

        // reset mid-packet
        out_tready = 1'b0;
        send(40'h9493929190, 1'b0);
        out_pulse();
        send(40'h9998979695, 1'b0);
        out_pulse();
        send(40'h9E9D9C9B9A, 1'b1);
        chk("mr_level7", level, 7);
        chk("mr_drain_ready", in_tready, 0);
        chk("mr_valid", out_tvalid, 1);
        #2 reset = 1'b1;
        #1;
        chk("mr_async_valid", out_tvalid, 0);
        chk("mr_async_level", level, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mr_rel_ready", in_tready, 1);
        chk("mr_rel_valid", out_tvalid, 0);
        chk("mr_rel_level", level, 0);
        @(negedge clk);
        out_tready = 1'b1;
        send(40'hA4A3A2A1A0, 1'b1);
        chk("mr_new_data", out_tdata, 32'hA3A2A1A0);
        chk("mr_new_level", level, 5);
        @(negedge clk);
        expect_beat("mr_tail", 32'h000000A4, 4'h1, 1'b1);

        // randomized regression over four width ratios
        rrst = 1'b0;
        @(negedge clk);
        rstart = 1'b1;
        begin
            int n = 0;
            while (!(g_rand[0].r_done && g_rand[1].r_done && g_rand[2].r_done &&
                     g_rand[3].r_done) && n < 30000) begin
                @(negedge clk);
                n++;
            end
            chk("rnd_finish", n < 30000, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    for (genvar g = 0; g < 4; g++) begin : g_rand
        localparam int IB = int'(CFG_IN[8*g +: 8]);
        localparam int OB = int'(CFG_OUT[8*g +: 8]);

        logic [8*IB-1:0] r_in_tdata;
        logic            r_in_tvalid, r_in_tlast, r_in_tready;
        logic [8*OB-1:0] r_out_tdata;
        logic [OB-1:0]   r_out_tkeep;
        logic            r_out_tlast, r_out_tvalid, r_out_tready;
        logic [4:0]      r_level;
        logic [7:0]      exp_q[$];
        logic            lst_q[$];
        logic            sent_done, r_done;

        axi_stream_width_conv #(.IN_BYTES(IB), .OUT_BYTES(OB), .DEPTH_BYTES(16)) u_dut (
            .clk(clk), .reset(rrst),
            .in_tdata(r_in_tdata), .in_tvalid(r_in_tvalid), .in_tlast(r_in_tlast),
            .in_tready(r_in_tready),
            .out_tdata(r_out_tdata), .out_tkeep(r_out_tkeep), .out_tlast(r_out_tlast),
            .out_tvalid(r_out_tvalid), .out_tready(r_out_tready), .level(r_level)
        );

        initial begin : drv
            r_in_tdata = '0; r_in_tvalid = 1'b0; r_in_tlast = 1'b0; sent_done = 1'b0;
            wait (rstart);
            for (int b = 0; b < NBEATS; b++) begin
                int n;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                for (int k = 0; k < IB; k++) r_in_tdata[8*k +: 8] = 8'($urandom);
                r_in_tlast  = (b == NBEATS-1) || ($urandom_range(0, 3) == 0);
                r_in_tvalid = 1'b1;
                n = 0;
                while (!r_in_tready && n < 200) begin @(negedge clk); n++; end
                chk($sformatf("rnd%0d_in_stall", g), n < 200, 1);
                for (int k = 0; k < IB; k++) begin
                    exp_q.push_back(r_in_tdata[8*k +: 8]);
                    lst_q.push_back(r_in_tlast && (k == IB-1));
                end
                @(negedge clk);
                r_in_tvalid = 1'b0;
            end
            sent_done = 1'b1;
        end

        initial begin : mon
            string           tg;
            int              n, idle, ph_cnt;
            logic            ph_hi, islast, pv;
            logic [8*OB-1:0] ed, pd;
            logic [OB-1:0]   pk;
            tg = $sformatf("rnd%0d", g);
            r_out_tready = 1'b0; r_done = 1'b0;
            pv = 1'b0; pd = '0; pk = '0; ph_hi = 1'b0; ph_cnt = 0; idle = 0;
            wait (rstart);
            while (!(sent_done && exp_q.size() == 0) && idle < 2000) begin
                if (ph_cnt == 0) begin
                    ph_hi  = !ph_hi;
                    ph_cnt = ph_hi ? $urandom_range(0, 6) : $urandom_range(1, 6);
                    if (ph_cnt == 0) begin ph_hi = 1'b0; ph_cnt = $urandom_range(1, 6); end
                end
                r_out_tready = ph_hi;
                ph_cnt--;
                if (pv) begin
                    chk({tg, "_hold_valid"}, r_out_tvalid, 1);
                    chk({tg, "_hold_data"}, r_out_tdata, pd);
                    chk({tg, "_hold_keep"}, r_out_tkeep, pk);
                end
                idle++;
                if (r_out_tvalid && r_out_tready) begin
                    n = 0; islast = 1'b0; ed = '0;
                    for (int i = 0; i < OB && i < exp_q.size() && !islast; i++) begin
                        ed[8*i +: 8] = exp_q[i];
                        islast = lst_q[i];
                        n++;
                    end
                    chk({tg, "_data"}, r_out_tdata, ed);
                    chk({tg, "_keep"}, r_out_tkeep, (64'd1 << n) - 64'd1);
                    chk({tg, "_last"}, r_out_tlast, islast);
                    repeat (n) begin
                        void'(exp_q.pop_front());
                        void'(lst_q.pop_front());
                    end
                    if (n > 0) idle = 0;
                end
                pv = r_out_tvalid && !r_out_tready;
                pd = r_out_tdata;
                pk = r_out_tkeep;
                @(negedge clk);
            end
            chk({tg, "_drained"}, exp_q.size(), 0);
            chk({tg, "_end_level"}, r_level, 0);
            chk({tg, "_end_valid"}, r_out_tvalid, 0);
            r_done = 1'b1;
        end
    end
endmodule
